// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction ROM and fills
// the IF/ID pipeline register. Supports delay-slot branches, flush and stalls.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_stall_i,
  input  logic        ifid_stall_i,
  input  logic        id_stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  input  logic [31:0] inst_rom_data_out_i,
  output logic [31:0] inst_rom_addr_in_o,
  output logic        inst_rom_ce_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o,
  output logic        align_err_o
);

  logic [31:0] pc_q, pc_d;
  logic        ce_q;
  logic        align_err_q, align_err_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_valid_q, id_valid_d;

  // Redirect targets are silently word-aligned; align_err_d flags the fixup.
  always_comb begin
    pc_d        = pc_q + 32'(PC_STEP);
    align_err_d = 1'b0;
    if (!ce_q) begin
      pc_d = RESET_PC;
    end else if (flush_i) begin
      pc_d        = {new_pc_i[31:2], 2'b00};
      align_err_d = (new_pc_i[1:0] != 2'b00);
    end else if (pc_stall_i) begin
      pc_d = pc_q;
    end else if (branch_flag_i) begin
      pc_d        = {branch_target_i[31:2], 2'b00};
      align_err_d = (branch_target_i[1:0] != 2'b00);
    end
  end

  always_comb begin
    id_pc_d    = pc_q;
    id_inst_d  = ce_q ? inst_rom_data_out_i : 32'h0;
    id_valid_d = ce_q;
    if (flush_i || (ifid_stall_i && !id_stall_i)) begin
      id_pc_d    = 32'h0;
      id_inst_d  = 32'h0;
      id_valid_d = 1'b0;
    end else if (ifid_stall_i && id_stall_i) begin
      id_pc_d    = id_pc_q;
      id_inst_d  = id_inst_q;
      id_valid_d = id_valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= RESET_PC;
      ce_q        <= 1'b0;
      align_err_q <= 1'b0;
      id_pc_q     <= 32'h0;
      id_inst_q   <= 32'h0;
      id_valid_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      ce_q        <= 1'b1;
      align_err_q <= align_err_d;
      id_pc_q     <= id_pc_d;
      id_inst_q   <= id_inst_d;
      id_valid_q  <= id_valid_d;
    end
  end

  assign inst_rom_addr_in_o = pc_q;
  assign inst_rom_ce_o      = ce_q;
  assign id_pc_o            = id_pc_q;
  assign id_inst_o          = id_inst_q;
  assign id_valid_o         = id_valid_q;
  assign align_err_o        = align_err_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage; the ROM is a pure function of address so
// expected instructions are computed from the expected fetch address.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcStall, ifidStall, idStall, branchFlag, flush;
  logic [31:0] branchTarget, newPc;
  logic [31:0] romData, romAddr;
  logic        romCe;
  logic [31:0] idPc, idInst;
  logic        idValid, alignErr;

  int totalChecks = 0;
  int badChecks   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] romFn(input logic [31:0] addr);
    return addr ^ 32'hC0DE_0000;
  endfunction

  assign romData = romFn(romAddr);

  if_stage dut (
    .clk                 (clk),
    .rst                 (rst),
    .pc_stall_i          (pcStall),
    .ifid_stall_i        (ifidStall),
    .id_stall_i          (idStall),
    .branch_flag_i       (branchFlag),
    .branch_target_i     (branchTarget),
    .flush_i             (flush),
    .new_pc_i            (newPc),
    .inst_rom_data_out_i (romData),
    .inst_rom_addr_in_o  (romAddr),
    .inst_rom_ce_o       (romCe),
    .id_pc_o             (idPc),
    .id_inst_o           (idInst),
    .id_valid_o          (idValid),
    .align_err_o         (alignErr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalChecks++;
    if (obs !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ps, input logic ifs, input logic ids,
                               input logic br, input logic [31:0] bt,
                               input logic fl, input logic [31:0] np);
    pcStall = ps; ifidStall = ifs; idStall = ids;
    branchFlag = br; branchTarget = bt; flush = fl; newPc = np;
  endtask

  task automatic expectFetch(input string tag, input logic [31:0] addr, input logic ce);
    checkOutput({tag, ".addr"}, romAddr, addr);
    checkOutput({tag, ".ce"}, {31'h0, romCe}, {31'h0, ce});
  endtask

  task automatic expectId(input string tag, input logic [31:0] pc, input logic valid);
    checkOutput({tag, ".idpc"}, idPc, valid ? pc : 32'h0);
    checkOutput({tag, ".idinst"}, idInst, valid ? romFn(pc) : 32'h0);
    checkOutput({tag, ".idvalid"}, {31'h0, idValid}, {31'h0, valid});
  endtask

  task automatic expectAlign(input string tag, input logic a);
    checkOutput({tag, ".align"}, {31'h0, alignErr}, {31'h0, a});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);

    // Reset and startup
    repeat (3) tick();
    expectFetch("rst", 32'h0, 1'b0);
    expectId("rst", 32'h0, 1'b0);
    expectAlign("rst", 1'b0);
    rst = 1'b1;
    tick();
    expectFetch("start0", 32'h0, 1'b1);
    expectId("start0", 32'h0, 1'b0);
    tick();
    expectFetch("start1", 32'h4, 1'b1);
    expectId("start1", 32'h0, 1'b1);
    tick();
    expectFetch("start2", 32'h8, 1'b1);
    expectId("start2", 32'h4, 1'b1);
    tick();
    expectFetch("start3", 32'hC, 1'b1);
    expectId("start3", 32'h8, 1'b1);
    tick();
    expectFetch("seq", 32'h10, 1'b1);
    tick();
    expectFetch("seq", 32'h14, 1'b1);
    expectId("br0", 32'h10, 1'b1);

    // Branch in decode while the delay slot is being fetched
    applyStimulus(0, 0, 0, 1, 32'h100, 0, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);
    expectFetch("br1", 32'h100, 1'b1);
    expectId("br1", 32'h14, 1'b1);
    tick();
    expectFetch("br2", 32'h104, 1'b1);
    expectId("br2", 32'h100, 1'b1);
    tick();
    expectId("br3", 32'h104, 1'b1);

    // Walk to PC=0x20 via a branch to 0x18
    applyStimulus(0, 0, 0, 1, 32'h18, 0, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);
    tick();
    tick();
    expectFetch("pre20", 32'h20, 1'b1);
    expectId("pre20", 32'h1C, 1'b1);

    // Stall with bubble insertion
    applyStimulus(1, 1, 0, 0, 32'h0, 0, 32'h0);
    tick();
    expectFetch("bub1", 32'h20, 1'b1);
    expectId("bub1", 32'h0, 1'b0);
    tick();
    expectFetch("bub2", 32'h20, 1'b1);
    expectId("bub2", 32'h0, 1'b0);
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);
    tick();
    expectFetch("bub3", 32'h24, 1'b1);
    expectId("bub3", 32'h20, 1'b1);
    tick();
    expectFetch("bub4", 32'h28, 1'b1);
    expectId("bub4", 32'h24, 1'b1);

    // Stall with decode also stalled: IF/ID holds
    applyStimulus(1, 1, 1, 0, 32'h0, 0, 32'h0);
    tick();
    expectFetch("hold1", 32'h28, 1'b1);
    expectId("hold1", 32'h24, 1'b1);
    tick();
    expectId("hold2", 32'h24, 1'b1);
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);
    tick();
    expectFetch("hold3", 32'h2C, 1'b1);
    expectId("hold3", 32'h28, 1'b1);

    // Flush beats stall and branch
    applyStimulus(1, 0, 0, 1, 32'h200, 1, 32'h80);
    tick();
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);
    expectFetch("flush1", 32'h80, 1'b1);
    expectId("flush1", 32'h0, 1'b0);
    expectAlign("flush1", 1'b0);
    tick();
    expectFetch("flush2", 32'h84, 1'b1);
    expectId("flush2", 32'h80, 1'b1);

    // Misaligned branch target
    applyStimulus(0, 0, 0, 1, 32'h103, 0, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);
    expectFetch("mis1", 32'h100, 1'b1);
    expectAlign("mis1", 1'b1);
    expectId("mis1", 32'h84, 1'b1);
    tick();
    expectFetch("mis2", 32'h104, 1'b1);
    expectAlign("mis2", 1'b0);

    // Misaligned flush target
    applyStimulus(0, 0, 0, 0, 32'h0, 1, 32'h0000_0302);
    tick();
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);
    expectFetch("misf", 32'h300, 1'b1);
    expectAlign("misf", 1'b1);

    // Wrap from the top of the address space
    applyStimulus(0, 0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC);
    tick();
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);
    expectFetch("wrap1", 32'hFFFF_FFFC, 1'b1);
    expectAlign("wrap1", 1'b0);
    tick();
    expectFetch("wrap2", 32'h0, 1'b1);
    expectId("wrap2", 32'hFFFF_FFFC, 1'b1);

    // Asynchronous reset between edges at PC=0x40
    applyStimulus(0, 0, 0, 0, 32'h0, 1, 32'h3C);
    tick();
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);
    tick();
    expectFetch("pre40", 32'h40, 1'b1);
    expectId("pre40", 32'h3C, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    expectFetch("arst", 32'h0, 1'b0);
    expectId("arst", 32'h0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    expectFetch("restart0", 32'h0, 1'b1);
    tick();
    expectFetch("restart1", 32'h4, 1'b1);
    expectId("restart1", 32'h0, 1'b1);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
